// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: queue entry payload,
// request state encoding and the default reset fetch address.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Fetch targets are word addresses; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries with push, pop and synchronous flush.
// Also exposes the post-update occupancy and the entry that will be at the head next cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output fetch_entry_t             head_nxt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] remain;
  logic          push_ok, pop_ok;
  fetch_entry_t  mem_q [DEPTH];

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    remain   = count_q - CW'(pop_ok);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = remain + CW'(push_ok);
    end
    // When nothing older survives the pop, the incoming word becomes the head.
    head_nxt = (remain == '0) ? push_data : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: request state machine, fetch PC and head output registers.
// Optional FETCH_PERF_EN adds a saturating bubble counter on perf_bubbles.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         head_valid, push, pop, space;
  logic [CW-1:0] count, count_nxt;
  fetch_entry_t push_data, head_nxt;

  assign head_valid  = (count != '0);
  assign instr_valid = head_valid && !redirect;
  assign pop         = instr_valid && !stall;
  assign push        = (state_q == REQ) && imem_ack && !redirect;
  assign push_data   = {imem_rdata, fetch_pc_q};
  // Slot for the next request, counted after this cycle's push, pop or flush.
  assign space       = count_nxt < CW'(DEPTH);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .count_nxt (count_nxt),
    .head_nxt  (head_nxt)
  );

  // Request sequencing; a completed or idle fetch reissues at once when a slot is free.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) fetch_pc_d = word_align(redirect_addr);
    unique case (state_q)
      IDLE: begin
        if (space) state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (!redirect) fetch_pc_d = fetch_pc_q + 32'd4;
          state_d = space ? REQ : IDLE;
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) state_d = space ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == REQ) || (state_d == DISCARD);
    addr_d = (state_d == REQ) ? fetch_pc_d : addr_q;
  end

  // Head registers follow the next-cycle head and hold their value when the queue drains.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (!redirect && (count_nxt != '0)) begin
      instr_d = head_nxt.instr;
      pc_d    = head_nxt.pc;
      pc4_d   = head_nxt.pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc4_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign pc4       = pc4_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (!head_valid && !redirect && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_bubbles = perf_q;
`endif

endmodule
